// File: rtl/fetch_pkg.sv
// ----------------------------------------------------------------------------
// fetch_pkg: shared types and constants for the instruction fetch stage.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package fetch_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    REQ  = 3'd1,
    WAIT = 3'd2,
    HOLD = 3'd3,
    DROP = 3'd4
  } fetch_state_e;

  localparam logic [1:0]  BR_SEL_PC4 = 2'b00;
  localparam logic [31:0] NOP_INSTR  = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        valid;
  } if_id_t;

endpackage

`default_nettype wire

// File: rtl/fetch_hold_buf.sv
// ----------------------------------------------------------------------------
// fetch_hold_buf: one-entry PC/instruction buffer used while ID is stalled.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module fetch_hold_buf #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              clear,
  input  logic [ADDR_W-1:0] pc_in,
  input  logic [31:0]       instr_in,
  output logic              valid,
  output logic [ADDR_W-1:0] pc_out,
  output logic [31:0]       instr_out
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid     <= 1'b0;
      pc_out    <= '0;
      instr_out <= '0;
    end else if (load) begin
      valid     <= 1'b1;
      pc_out    <= pc_in;
      instr_out <= instr_in;
    end else if (clear) begin
      valid     <= 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: rtl/if_fetch_unit.sv
// ----------------------------------------------------------------------------
// if_fetch_unit: PC, single-outstanding imem fetch FSM and IF/ID register.
// Optional counters under IF_FETCH_PERF_CNT_EN. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module if_fetch_unit #(
  parameter int               ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter logic [31:0]      NOP_INSTR = fetch_pkg::NOP_INSTR
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pc_write,
  input  logic              instr_flush,
  input  logic              IF_ID_reg_write,
  input  logic [1:0]        branch_sel,
  input  logic [ADDR_W-1:0] branch_target,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [ADDR_W-1:0] imem_req_addr,
  input  logic              imem_rsp_valid,
  input  logic [31:0]       imem_rsp_data,
  output logic [ADDR_W-1:0] ID_pc,
  output logic [31:0]       ID_instr,
  output logic              ID_valid,
`ifdef IF_FETCH_PERF_CNT_EN
  output logic [31:0]       perf_fetched,
  output logic [31:0]       perf_dropped,
  output logic [31:0]       perf_stall,
`endif
  output logic              fetch_busy
);

  import fetch_pkg::*;

  fetch_state_e      state, state_nxt;
  logic [ADDR_W-1:0] pc, pc_nxt, pc_inc, req_addr;
  logic              drop;
  if_id_t            if_id, if_id_nxt;

  logic              redirect, kill, have_instr, take, hold_load, hold_clear;
  logic              hold_valid;
  logic [ADDR_W-1:0] hold_pc;
  logic [31:0]       hold_instr;

  assign pc_inc     = pc + ADDR_W'(4);
  assign redirect   = pc_write && (branch_sel != BR_SEL_PC4);
  // A flush without redirect discards the instruction and refetches the same pc.
  assign kill       = redirect || (instr_flush && IF_ID_reg_write && pc_write);
  assign have_instr = ((state == WAIT) && imem_rsp_valid) || ((state == HOLD) && hold_valid);
  assign take       = have_instr && IF_ID_reg_write && pc_write && !kill;
  assign hold_load  = (state == WAIT) && imem_rsp_valid && !take && !kill;
  assign hold_clear = (state == HOLD) && (take || kill);

  fetch_hold_buf #(.ADDR_W(ADDR_W)) u_hold_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (hold_load),
    .clear     (hold_clear),
    .pc_in     (pc),
    .instr_in  (imem_rsp_data),
    .valid     (hold_valid),
    .pc_out    (hold_pc),
    .instr_out (hold_instr)
  );

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: state_nxt = REQ;
      REQ:  if (imem_req_ready) state_nxt = (drop || redirect) ? DROP : WAIT;
      WAIT: begin
        if (imem_rsp_valid)  state_nxt = (take || kill) ? REQ : HOLD;
        else if (redirect)   state_nxt = DROP;
      end
      HOLD: if (take || kill) state_nxt = REQ;
      DROP: if (imem_rsp_valid) state_nxt = REQ;
      default: state_nxt = IDLE;
    endcase

    if (redirect)  pc_nxt = branch_target;
    else if (take) pc_nxt = pc_inc;
    else           pc_nxt = pc;

    if_id_nxt = if_id;
    if (!IF_ID_reg_write) begin
      if_id_nxt = if_id;
    end else if (instr_flush) begin
      if_id_nxt.instr = NOP_INSTR;
      if_id_nxt.valid = 1'b0;
    end else if (take) begin
      if_id_nxt.pc    = (state == HOLD) ? 32'(hold_pc) : 32'(pc);
      if_id_nxt.instr = (state == HOLD) ? hold_instr : imem_rsp_data;
      if_id_nxt.valid = 1'b1;
    end else begin
      if_id_nxt.instr = NOP_INSTR;
      if_id_nxt.valid = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      pc       <= RESET_PC;
      req_addr <= RESET_PC;
      drop     <= 1'b0;
      if_id    <= '{pc: 32'(RESET_PC), instr: NOP_INSTR, valid: 1'b0};
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
      if_id <= if_id_nxt;
      // The request address is captured on entry so it stays stable until accepted.
      if ((state_nxt == REQ) && (state != REQ)) req_addr <= pc_nxt;
      if (state == REQ) begin
        if (imem_req_ready) drop <= 1'b0;
        else if (redirect)  drop <= 1'b1;
      end
    end
  end

  assign imem_req_valid = (state == REQ);
  assign imem_req_addr  = req_addr;
  assign fetch_busy     = (state == REQ) || (state == WAIT) || (state == DROP);
  assign ID_pc          = if_id.pc[ADDR_W-1:0];
  assign ID_instr       = if_id.instr;
  assign ID_valid       = if_id.valid;

`ifdef IF_FETCH_PERF_CNT_EN
  logic rsp_discard;
  assign rsp_discard = (have_instr && kill) || ((state == DROP) && imem_rsp_valid);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_fetched <= '0;
      perf_dropped <= '0;
      perf_stall   <= '0;
    end else begin
      if (take)             perf_fetched <= perf_fetched + 32'd1;
      if (rsp_discard)      perf_dropped <= perf_dropped + 32'd1;
      if (!IF_ID_reg_write) perf_stall   <= perf_stall + 32'd1;
    end
  end
`endif

endmodule

`default_nettype wire

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
- Fetch stage plus IF/ID pipeline register; the consumer of the hazard controller's pc_write / instr_flush / IF_ID_reg_write / branch_sel.
- Owns the PC and issues single-outstanding requests to instruction memory over a valid/ready request channel and a valid-only response channel.
- Delivers {pc, instr, valid} to ID.
- Drops in-flight responses after a redirect and holds a returned instruction while ID is stalled.

Parameters:
- ADDR_W, 32, PC / instruction-address width.
- RESET_PC, 32'h0000_0000, PC value after reset.
- NOP_INSTR, 32'h0000_0013, bubble encoding (addi x0,x0,0) written to ID on flush or empty fetch.

Ports:
- clk  in  1  clock.
- rst_n  in  1  async active-low reset.
- pc_write  in  1  from hazard ctrl; 0 freezes PC and request issue.
- instr_flush  in  1  from hazard ctrl; bubble into IF/ID.
- IF_ID_reg_write  in  1  from hazard ctrl; 0 holds IF/ID register.
- branch_sel  in  2  2'b00 = PC+4, otherwise redirect.
- branch_target  in  ADDR_W  redirect PC, valid when branch_sel != 0.
- imem_req_valid  out  1  request valid.
- imem_req_ready  in  1  request accepted.
- imem_req_addr  out  ADDR_W  request address.
- imem_rsp_valid  in  1  response valid, 1-cycle pulse, in order.
- imem_rsp_data  in  32  instruction.
- ID_pc  out  ADDR_W  IF/ID PC.
- ID_instr  out  32  IF/ID instruction.
- ID_valid  out  1  IF/ID holds a real instruction.
- fetch_busy  out  1  request outstanding or drop pending.

Behaviour:
- Reset (async, rst_n=0):
  - pc = RESET_PC; state = IDLE; hold_valid = 0; drop = 0.
  - ID_pc = RESET_PC, ID_instr = NOP_INSTR, ID_valid = 0.
  - imem_req_valid = 0.
  - Reset mid-transaction: any later response for the pre-reset request is ignored, because the state is not WAIT/DROP.
- FSM states:
  - IDLE: one cycle after reset, then REQ.
  - REQ: imem_req_valid=1, imem_req_addr=pc. While valid, the address is stable until accepted. On ready: go to DROP if drop is set, else WAIT. drop is cleared on entry to DROP.
  - WAIT: await imem_rsp_valid.
    - Response with IF_ID_reg_write=1: load ID, pc <= pc+4 (ADDR_W wrap), go to REQ.
    - Response with IF_ID_reg_write=0: latch into the hold buffer (hold_valid=1), go to HOLD.
  - HOLD: no request issued. On IF_ID_reg_write=1: load ID from the hold buffer, clear hold_valid, pc <= pc+4, go to REQ.
  - DROP: the next imem_rsp_valid is discarded, then go to REQ with the already-updated pc.
- Redirect (branch_sel != 0, pc_write=1):
  - pc <= branch_target.
  - State REQ not yet accepted: set drop.
  - State REQ accepted the same cycle: go to DROP.
  - State WAIT without a response this cycle: go to DROP.
  - State WAIT with a response this cycle, or state HOLD: discard that instruction, clear hold_valid, go to REQ.
  - Redirect overrides normal PC+4 increment.
- pc_write=0 (load-use stall): no new request enters REQ from WAIT/HOLD; the pc increment is deferred. An accepted in-flight request still completes into HOLD.
- IF/ID register priority, evaluated at clock edge:
  - 1. IF_ID_reg_write=0: hold.
  - 2. instr_flush=1: ID_instr=NOP_INSTR, ID_valid=0, ID_pc unchanged.
  - 3. Instruction available from response or hold buffer: load it, ID_valid=1.
  - 4. Otherwise: bubble (NOP_INSTR, ID_valid=0).
- Flush and response in the same cycle: the response is dropped, the bubble is written, and pc takes branch_target.
- Latency: with zero-wait memory (ready=1, response the cycle after accept), the first valid ID instruction appears 3 cycles after reset release. Steady state delivers 1 instruction per 2 cycles, because only one request is outstanding.
- fetch_busy = 1 in states REQ, WAIT, DROP.

Optional Feature:
- Macro: IF_FETCH_PERF_CNT_EN.
- Defined: adds outputs perf_fetched (32, count of instructions loaded into ID with valid=1), perf_dropped (32, count of discarded responses from DROP/flush/HOLD), and perf_stall (32, count of cycles with IF_ID_reg_write=0). All reset to 0 and wrap.
- Undefined: the ports and counters are absent; no other behaviour change.

Decomposition:
- Shared package fetch_pkg:
  - fetch_state_e enum (IDLE, REQ, WAIT, HOLD, DROP).
  - BR_SEL_PC4 = 2'b00.
  - NOP_INSTR constant.
  - if_id_t struct {pc, instr, valid}.
- Sub-module fetch_hold_buf: 1-entry instruction/PC buffer with load/clear/valid. This is the natural split; the FSM and PC stay in the top module.

Test Plan:
- Reset release, ready=1, 1-cycle response latency: imem_req_addr sequence 0x0, 0x4, 0x8. ID_valid rises on cycle 3 with ID_pc=0x0.
- IF_ID_reg_write=0 and pc_write=0 for 3 cycles while the response for 0x8 arrives: ID holds 0x4. State HOLD; after release ID_pc=0x8, next request 0xC.
- branch_sel=2'b01, target 0x100 while WAIT on 0x10: the 0x10 response is discarded (ID_valid=0, NOP). Next request 0x100, then ID_pc=0x100.
- Redirect while REQ is stalled by imem_req_ready=0: imem_req_addr stays 0x20 until ready. The response is dropped, then a request to target 0x200 is issued.
- Redirect, instr_flush and response in the same cycle: ID_instr=32'h13, ID_valid=0, pc=target, no DROP state entered.
- With IF_FETCH_PERF_CNT_EN: run 10 fetches with one redirect and 2 stall cycles. Expect perf_fetched=10, perf_dropped=1, perf_stall=2.
